score_display: RTL and testbench

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display_pkg.sv | 49 ++++
 rtl/score_display_seg7_decode.sv | 27 ++
 rtl/score_display.sv | 220 ++++++++++++++++++++++
 tb/tb_score_display.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display: FSM states, segment bit
// order and active-low seven-segment glyphs.
package score_display_pkg;

   typedef enum logic [1:0] {
      ST_SHOW  = 2'd0,
      ST_FLASH = 2'd1,
      ST_WIN   = 2'd2
   } disp_state_e;

   // Segment bit positions inside HEX_OUT (all active-low).
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   localparam logic [7:0] GLYPH_0     = 8'b1100_0000;
   localparam logic [7:0] GLYPH_1     = 8'b1111_1001;
   localparam logic [7:0] GLYPH_2     = 8'b1010_0100;
   localparam logic [7:0] GLYPH_3     = 8'b1011_0000;
   localparam logic [7:0] GLYPH_4     = 8'b1001_1001;
   localparam logic [7:0] GLYPH_5     = 8'b1001_0010;
   localparam logic [7:0] GLYPH_6     = 8'b1000_0010;
   localparam logic [7:0] GLYPH_7     = 8'b1111_1000;
   localparam logic [7:0] GLYPH_8     = 8'b1000_0000;
   localparam logic [7:0] GLYPH_9     = 8'b1001_0000;
   localparam logic [7:0] GLYPH_DASH  = 8'b1011_1111;
   localparam logic [7:0] GLYPH_BLANK = 8'b1111_1111;

   localparam logic [3:0] ANODES_OFF  = 4'b1111;

   // One-hot-low anode pattern for a strobe slot.
   function automatic logic [3:0] anode_for_slot(input logic [1:0] slot);
      logic [3:0] sel;
      case (slot)
         2'd0:    sel = 4'b1110;
         2'd1:    sel = 4'b1101;
         2'd2:    sel = 4'b1011;
         2'd3:    sel = 4'b0111;
         default: sel = ANODES_OFF;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/score_display_seg7_decode.sv
// Combinational 4-bit value to active-low seven-segment glyph decoder;
// values above 9 decode to a blank digit.
module seg7_decode
   import score_display_pkg::*;
(
   input  logic [3:0] value_i,
   output logic [7:0] glyph_o
);

   // Glyph lookup
   always_comb begin
      case (value_i)
         4'd0:    glyph_o = GLYPH_0;
         4'd1:    glyph_o = GLYPH_1;
         4'd2:    glyph_o = GLYPH_2;
         4'd3:    glyph_o = GLYPH_3;
         4'd4:    glyph_o = GLYPH_4;
         4'd5:    glyph_o = GLYPH_5;
         4'd6:    glyph_o = GLYPH_6;
         4'd7:    glyph_o = GLYPH_7;
         4'd8:    glyph_o = GLYPH_8;
         4'd9:    glyph_o = GLYPH_9;
         default: glyph_o = GLYPH_BLANK;
      endcase
   end

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed score display with score-change flash (DP on units)
// and a blinking win indication; free-running digit strobe.
module score_display
   import score_display_pkg::*;
#(
   parameter int REFRESH_DIV  = 50000,
   parameter int FLASH_FRAMES = 64,
   parameter int BLINK_FRAMES = 128,
   parameter int WIN_SCORE    = 10
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] CURRENT_SCORE,
   output logic [3:0] SEG_SELECT,
   output logic [7:0] HEX_OUT
);

   localparam int PRESC_W = $clog2(REFRESH_DIV + 1);
   localparam int FC_W    = $clog2(FLASH_FRAMES + 1);
   localparam int BC_W    = $clog2(BLINK_FRAMES + 1);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
   localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
   localparam logic [FC_W-1:0]    FLASH_LOAD = FC_W'(FLASH_FRAMES);
   localparam logic [FC_W-1:0]    FC_ONE     = FC_W'(1);
   localparam logic [BC_W-1:0]    BLINK_LAST = BC_W'(BLINK_FRAMES - 1);
   localparam logic [BC_W-1:0]    BC_ONE     = BC_W'(1);
   localparam logic [3:0]         WIN_VAL    = 4'(WIN_SCORE);

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [1:0]         strobe_q, strobe_d;
   logic [3:0]         score_q, score_prev_q;
   disp_state_e        state_q, state_d;
   logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
   logic [BC_W-1:0]    blink_cnt_q, blink_cnt_d;
   logic               blink_off_q, blink_off_d;
   logic               rst_dly_q;
   logic [3:0]         seg_select_q, seg_select_d;
   logic [7:0]         hex_out_q, hex_out_d;

   logic               slot_tick_s, frame_tick_s;
   logic               is_win_s, rising_s, abort_s, out_of_range_s, tens_one_s;
   logic [3:0]         units_s, digit_s;
   logic [7:0]         glyph_s;

   // Free-running slot prescaler and digit strobe
   always_comb begin
      slot_tick_s  = (presc_q == PRESC_LAST);
      frame_tick_s = slot_tick_s && (strobe_q == 2'd3);
      if (slot_tick_s) begin
         presc_d  = '0;
         strobe_d = strobe_q + 2'd1;
      end else begin
         presc_d  = presc_q + PRESC_ONE;
         strobe_d = strobe_q;
      end
   end

   // Score classification; out-of-range values never start a flash
   always_comb begin
      is_win_s       = (score_q == WIN_VAL);
      out_of_range_s = (score_q > WIN_VAL);
      rising_s       = (score_q > score_prev_q) && (score_q < WIN_VAL);
      abort_s        = (score_q < score_prev_q) || out_of_range_s;
      if (score_q >= 4'd10) begin
         tens_one_s = 1'b1;
         units_s    = score_q - 4'd10;
      end else begin
         tens_one_s = 1'b0;
         units_s    = score_q;
      end
   end

   // Display FSM with flash frame counter and win blink phase
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      blink_cnt_d = blink_cnt_q;
      blink_off_d = blink_off_q;
      if (is_win_s) begin
         state_d     = ST_WIN;
         frame_cnt_d = '0;
         if (state_q != ST_WIN) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
         end else if (frame_tick_s) begin
            if (blink_cnt_q == BLINK_LAST) begin
               blink_cnt_d = '0;
               blink_off_d = ~blink_off_q;
            end else begin
               blink_cnt_d = blink_cnt_q + BC_ONE;
            end
         end else begin
            blink_cnt_d = blink_cnt_q;
         end
      end else begin
         blink_cnt_d = '0;
         blink_off_d = 1'b0;
         case (state_q)
            ST_SHOW: begin
               if (rising_s) begin
                  state_d     = ST_FLASH;
                  frame_cnt_d = FLASH_LOAD;
               end else begin
                  state_d = ST_SHOW;
               end
            end
            ST_FLASH: begin
               if (rising_s) begin
                  frame_cnt_d = FLASH_LOAD;
               end else if (abort_s) begin
                  state_d     = ST_SHOW;
                  frame_cnt_d = '0;
               end else if (frame_tick_s) begin
                  if (frame_cnt_q <= FC_ONE) begin
                     state_d     = ST_SHOW;
                     frame_cnt_d = '0;
                  end else begin
                     frame_cnt_d = frame_cnt_q - FC_ONE;
                  end
               end else begin
                  frame_cnt_d = frame_cnt_q;
               end
            end
            ST_WIN: begin
               state_d     = ST_SHOW;
               frame_cnt_d = '0;
            end
            default: begin
               state_d     = ST_SHOW;
               frame_cnt_d = '0;
            end
         endcase
      end
   end

   // Digit selection for the shared decoder: tens is only ever a 1
   always_comb begin
      if (strobe_q == 2'd1) begin
         digit_s = 4'd1;
      end else begin
         digit_s = units_s;
      end
   end

   seg7_decode u_decode (
      .value_i (digit_s),
      .glyph_o (glyph_s)
   );

   // Next anode/segment pattern; blank for one cycle after reset release
   always_comb begin
      seg_select_d = ANODES_OFF;
      hex_out_d    = GLYPH_BLANK;
      if (rst_dly_q) begin
         seg_select_d = ANODES_OFF;
      end else if ((state_q == ST_WIN) && blink_off_q) begin
         seg_select_d = ANODES_OFF;
      end else begin
         seg_select_d = anode_for_slot(strobe_q);
         case (strobe_q)
            2'd0: begin
               if (out_of_range_s) begin
                  hex_out_d = GLYPH_DASH;
               end else begin
                  hex_out_d = glyph_s;
                  if (state_q == ST_FLASH) begin
                     hex_out_d[SEG_DP] = 1'b0;
                  end else begin
                     hex_out_d[SEG_DP] = 1'b1;
                  end
               end
            end
            2'd1: begin
               if (out_of_range_s) begin
                  hex_out_d = GLYPH_DASH;
               end else if (tens_one_s) begin
                  hex_out_d = glyph_s;
               end else begin
                  hex_out_d = GLYPH_BLANK;
               end
            end
            default: hex_out_d = GLYPH_BLANK;
         endcase
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         presc_q      <= '0;
         strobe_q     <= 2'd0;
         score_q      <= 4'd0;
         score_prev_q <= 4'd0;
         state_q      <= ST_SHOW;
         frame_cnt_q  <= '0;
         blink_cnt_q  <= '0;
         blink_off_q  <= 1'b0;
         rst_dly_q    <= 1'b1;
         seg_select_q <= ANODES_OFF;
         hex_out_q    <= GLYPH_BLANK;
      end else begin
         presc_q      <= presc_d;
         strobe_q     <= strobe_d;
         score_q      <= CURRENT_SCORE;
         score_prev_q <= score_q;
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_off_q  <= blink_off_d;
         rst_dly_q    <= 1'b0;
         seg_select_q <= seg_select_d;
         hex_out_q    <= hex_out_d;
      end
   end

   assign SEG_SELECT = seg_select_q;
   assign HEX_OUT    = hex_out_q;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: stimulus pushes expected display words
// from a frame-arithmetic reference model; a monitor pops and compares.
module tb_score_display;

   localparam int DIV  = 4;
   localparam int FLF  = 3;
   localparam int BLF  = 2;
   localparam int WIN  = 10;
   localparam int P    = 4 * DIV;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [3:0] CURRENT_SCORE;
   logic [3:0] SEG_SELECT;
   logic [7:0] HEX_OUT;

   score_display #(
      .REFRESH_DIV  (DIV),
      .FLASH_FRAMES (FLF),
      .BLINK_FRAMES (BLF),
      .WIN_SCORE    (WIN)
   ) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .CURRENT_SCORE (CURRENT_SCORE),
      .SEG_SELECT    (SEG_SELECT),
      .HEX_OUT       (HEX_OUT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] sel;
      logic [7:0] hex;
      string      tag;
   } exp_t;

   exp_t       sb_q[$];
   int         n_vec = 0;
   int         n_bad = 0;
   bit         started = 1'b0;
   bit         done = 1'b0;
   logic [7:0] glyph [10];

   // Reference model state: edges since reset, sampled score and its previous
   // value, mode (0 show, 1 flash, 2 win) and the frame index a flash/win began.
   int m_k, m_sq, m_sp, m_mode, m_flash0, m_win0;
   bit m_first;

   function automatic exp_t view(int slot, int mode, int sq, int phase, bit first);
      exp_t v;
      v.sel = 4'hF;
      v.hex = 8'hFF;
      v.tag = "";
      if (first || (mode == 2 && phase == 1)) return v;
      v.sel = 4'hF & ~(4'b0001 << slot);
      if (slot == 0) begin
         if (sq > WIN) v.hex = 8'hBF;
         else v.hex = glyph[sq % 10] & ((mode == 1) ? 8'h7F : 8'hFF);
      end else if (slot == 1) begin
         if (sq > WIN) v.hex = 8'hBF;
         else if (sq / 10 == 1) v.hex = glyph[1];
         else v.hex = 8'hFF;
      end
      return v;
   endfunction

   task automatic step(input bit rst, input int score, input string tag);
      exp_t e;
      int   slot, ft, phase;
      bit   inc;
      @(negedge CLK);
      RESET = rst;
      CURRENT_SCORE = 4'(score);
      if (rst) begin
         e.sel = 4'hF;
         e.hex = 8'hFF;
         m_k = 0; m_sq = 0; m_sp = 0; m_mode = 0; m_first = 1'b1;
      end else begin
         m_k++;
         slot = ((m_k - 1) / DIV) % 4;
         ft   = (m_k - 1) / P;
         if (m_mode == 1 && ft - m_flash0 >= FLF) m_mode = 0;
         phase = (m_mode == 2) ? ((ft - m_win0) / BLF) % 2 : 0;
         e = view(slot, m_mode, m_sq, phase, m_first);
         m_first = 1'b0;
         inc = (m_sq > m_sp) && (m_sq < WIN);
         if (m_sq == WIN) begin
            if (m_mode != 2) begin
               m_mode = 2;
               m_win0 = m_k / P;
            end
         end else if (m_mode == 2) begin
            m_mode = 0;
         end else if (inc) begin
            m_mode = 1;
            m_flash0 = m_k / P;
         end else if (m_mode == 1 && (m_sq < m_sp || m_sq > WIN)) begin
            m_mode = 0;
         end
         m_sp = m_sq;
         m_sq = score;
      end
      e.tag = tag;
      sb_q.push_back(e);
      started = 1'b1;
   endtask

   task automatic run(input int n, input int score, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, score, tag);
   endtask

   // Monitor: compare one expected word per clock, away from the active edge
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #2;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (SEG_SELECT !== e.sel || HEX_OUT !== e.hex) begin
               n_bad++;
               $display("FAIL %s t=%0t: got SEG_SELECT=%b HEX_OUT=%h, want SEG_SELECT=%b HEX_OUT=%h",
                        e.tag, $time, SEG_SELECT, HEX_OUT, e.sel, e.hex);
            end
         end else if (started && !done) begin
            n_bad++;
            $display("FAIL scoreboard_underflow t=%0t: got empty queue, want one entry", $time);
         end
      end
   end

   initial begin
      int score, hold;
      glyph[0] = 8'hC0; glyph[1] = 8'hF9; glyph[2] = 8'hA4; glyph[3] = 8'hB0;
      glyph[4] = 8'h99; glyph[5] = 8'h92; glyph[6] = 8'h82; glyph[7] = 8'hF8;
      glyph[8] = 8'h80; glyph[9] = 8'h90;
      RESET = 1'b1;
      CURRENT_SCORE = 4'd0;

      for (int i = 0; i < 3; i++) step(1'b1, 0, "reset");
      run(2 * P + 3, 0, "strobe_zero");
      run((FLF + 2) * P, 7, "flash_seven");
      run((2 * BLF + 2) * P, 10, "win_blink");
      run(2 * P, 12, "out_of_range");
      run(2 * P, 3, "back_to_three");
      run(P + 7, 4, "first_flash");
      run((FLF + 1) * P, 5, "reflash");
      run(2 * P, 0, "drop_to_zero");
      run(P + 5, 10, "win_again");
      step(1'b1, 10, "reset_in_win");
      run(2 * P, 10, "after_reset_win");
      run(P, 2, "after_reset_show");

      score = 0;
      for (int s = 0; s < 250; s++) begin
         if ($urandom_range(0, 24) == 0) begin
            for (int r = 0; r < int'($urandom_range(1, 2)); r++) step(1'b1, score, "rand_reset");
         end
         case ($urandom_range(0, 7))
            0, 1, 2: score = (score + int'($urandom_range(1, 2))) % 16;
            3:       score = WIN;
            4:       score = 0;
            5:       score = (score > 0) ? score - 1 : 0;
            default: score = $urandom_range(0, 15);
         endcase
         hold = $urandom_range(1, 3 * P);
         run(hold, score, "random");
      end
      done = 1'b1;

      for (int w = 0; w < 4 && sb_q.size() != 0; w++) @(posedge CLK);
      @(negedge CLK);
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
